// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: single-clock AHB-to-APB bridge with one outstanding transfer,
// error response forwarding and an optional ACCESS-phase timeout.
`default_nettype none

module ahb2apb_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;

  localparam bit         C_TO_EN   = (TIMEOUT > 0);
  localparam logic [7:0] C_TO_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [31:0] r_hrdata;
  logic        r_pwrite;
  logic        w_accept;
  logic        w_can_accept;
  logic        w_hreadyout;
  logic        w_hresp;
  logic        w_psel;
  logic        w_penable;
  logic        w_unused;

  // SEQ and NONSEQ are treated alike, so only HTRANS[1] matters.
  assign w_unused     = HTRANS[0];
  assign w_can_accept = (r_state == IDLE) || (r_state == ERR2);
  assign w_accept     = w_can_accept && HSEL && HREADYIN && HTRANS[1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_hreadyout  = 1'b0;
    w_hresp      = 1'b0;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
    case (r_state)
      IDLE, ERR2: begin
        w_hreadyout = 1'b1;
        w_hresp     = (r_state == ERR2);
        if (w_accept) begin
          w_next_state = HWRITE ? WDATA : SETUP;
        end else begin
          w_next_state = IDLE;
        end
      end
      WDATA: w_next_state = SETUP;
      SETUP: begin
        w_psel       = 1'b1;
        w_next_state = ACCESS;
      end
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (PREADY) begin
          w_next_state = PSLVERR ? ERR1 : IDLE;
        end else if (C_TO_EN && (r_cnt == C_TO_LAST)) begin
          w_next_state = ERR1;
        end
      end
      ERR1: begin
        w_hresp      = 1'b1;
        w_next_state = ERR2;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Counter restarts from zero on every entry into ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_paddr  <= 32'd0;
      r_pwrite <= 1'b0;
      r_pwdata <= 32'd0;
      r_hrdata <= 32'd0;
      r_cnt    <= 8'd0;
    end else begin
      if (w_accept) begin
        r_paddr  <= HADDR;
        r_pwrite <= HWRITE;
      end
      if (r_state == WDATA) begin
        r_pwdata <= HWDATA;
      end
      if ((r_state == ACCESS) && PREADY && !PSLVERR && !r_pwrite) begin
        r_hrdata <= PRDATA;
      end
      r_cnt <= (r_state == ACCESS) ? r_cnt + 8'd1 : 8'd0;
    end
  end

  assign HREADYOUT = w_hreadyout;
  assign HRESP     = w_hresp;
  assign PSEL      = w_psel;
  assign PENABLE   = w_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign HRDATA    = r_hrdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: directed bench for ahb2apb_bridge (TIMEOUT=4) with a read-data scoreboard.
`default_nettype none

module tb_ahb2apb_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] sb_q[$];

  ahb2apb_bridge #(.TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    if (sb_q.size() == 0) begin
      n_asserts++;
      n_fail++;
      $error("FAIL %s: observed HRDATA %h with empty scoreboard, expected a queued read", tag, HRDATA);
    end else begin
      chk(tag, HRDATA, sb_q.pop_front());
    end
  endtask

  task automatic present(input logic wr, input logic [31:0] addr);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR  = addr;
  endtask

  task automatic idle_bus();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = 32'hFFFF_FFF0;
  endtask

  task automatic chk_apb(input string tag, input logic sel, input logic en,
                         input logic hrdy, input logic hrsp);
    chk({tag, ".psel"},    {31'd0, PSEL},      {31'd0, sel});
    chk({tag, ".penable"}, {31'd0, PENABLE},   {31'd0, en});
    chk({tag, ".hready"},  {31'd0, HREADYOUT}, {31'd0, hrdy});
    chk({tag, ".hresp"},   {31'd0, HRESP},     {31'd0, hrsp});
  endtask

  initial begin
    PRESETn  = 1'b1;
    HREADYIN = 1'b1;
    HWDATA   = 32'd0;
    PRDATA   = 32'd0;
    PREADY   = 1'b1;
    PSLVERR  = 1'b0;
    idle_bus();

    // Reset values, forced asynchronously before any clock edge.
    #2 PRESETn = 1'b0;
    #1;
    chk_apb("rst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst.paddr",  PADDR,  32'd0);
    chk("rst.pwdata", PWDATA, 32'd0);
    chk("rst.hrdata", HRDATA, 32'd0);
    chk("rst.pwrite", {31'd0, PWRITE}, 32'd0);
    tick();
    tick();
    PRESETn = 1'b1;
    tick();

    // Ignored transfers: BUSY, HSEL low, HREADYIN low.
    HSEL = 1'b1; HTRANS = 2'b01;
    tick();
    chk_apb("ign.busy", 1'b0, 1'b0, 1'b1, 1'b0);
    HSEL = 1'b0; HTRANS = 2'b10;
    tick();
    chk_apb("ign.nosel", 1'b0, 1'b0, 1'b1, 1'b0);
    HSEL = 1'b1; HREADYIN = 1'b0;
    tick();
    chk_apb("ign.nordy", 1'b0, 1'b0, 1'b1, 1'b0);
    HREADYIN = 1'b1;
    idle_bus();
    tick();

    // Zero-wait write.
    present(1'b1, 32'h0000_0010);
    tick();
    idle_bus();
    HWDATA = 32'hDEAD_BEEF;
    chk_apb("wr.t1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    HWDATA = 32'h0;
    chk_apb("wr.t2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr.t2.paddr",  PADDR,  32'h10);
    chk("wr.t2.pwdata", PWDATA, 32'hDEAD_BEEF);
    chk("wr.t2.pwrite", {31'd0, PWRITE}, 32'd1);
    tick();
    chk_apb("wr.t3", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wr.t3.paddr",  PADDR,  32'h10);
    chk("wr.t3.pwdata", PWDATA, 32'hDEAD_BEEF);
    tick();
    chk_apb("wr.t4", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("wr.t4.hrdata", HRDATA, 32'd0);

    // Zero-wait read.
    present(1'b0, 32'h0000_0010);
    PRDATA = 32'h1234_5678;
    sb_q.push_back(32'h1234_5678);
    tick();
    idle_bus();
    chk_apb("rd.t1", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rd.t1.pwrite", {31'd0, PWRITE}, 32'd0);
    tick();
    chk_apb("rd.t2", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_apb("rd.t3", 1'b0, 1'b0, 1'b1, 1'b0);
    sb_check("rd.t3.hrdata");

    // Read with three wait states, then a back-to-back read in the completing cycle.
    present(1'b0, 32'h0000_0020);
    PRDATA = 32'hA5A5_0001;
    PREADY = 1'b0;
    sb_q.push_back(32'hA5A5_0001);
    tick();
    idle_bus();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_apb("rdw.acc", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("rdw.acc.paddr", PADDR, 32'h20);
      chk("rdw.acc.hrdata", HRDATA, 32'h1234_5678);
      if (i == 3) PREADY = 1'b1;
      tick();
    end
    chk_apb("rdw.done", 1'b0, 1'b0, 1'b1, 1'b0);
    sb_check("rdw.hrdata");
    present(1'b0, 32'h0000_0030);
    PRDATA = 32'hCAFE_0001;
    sb_q.push_back(32'hCAFE_0001);
    tick();
    idle_bus();
    chk_apb("b2b.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b.paddr", PADDR, 32'h30);
    tick();
    tick();
    chk_apb("b2b.done", 1'b0, 1'b0, 1'b1, 1'b0);
    sb_check("b2b.hrdata");

    // Write with slave error.
    present(1'b1, 32'h0000_0040);
    tick();
    idle_bus();
    HWDATA = 32'h0BAD_0040;
    tick();
    tick();
    PSLVERR = 1'b1;
    tick();
    PSLVERR = 1'b0;
    chk_apb("werr.err1", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_apb("werr.err2", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_apb("werr.idle", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("werr.hrdata", HRDATA, 32'hCAFE_0001);

    // Read with slave error keeps HRDATA; a new read is accepted from ERR2.
    present(1'b0, 32'h0000_0050);
    PRDATA = 32'hBAD0_BAD0;
    tick();
    idle_bus();
    tick();
    PSLVERR = 1'b1;
    tick();
    PSLVERR = 1'b0;
    chk_apb("rerr.err1", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rerr.hrdata", HRDATA, 32'hCAFE_0001);
    tick();
    chk_apb("rerr.err2", 1'b0, 1'b0, 1'b1, 1'b1);
    present(1'b0, 32'h0000_0060);
    PRDATA = 32'h600D_0060;
    sb_q.push_back(32'h600D_0060);
    tick();
    idle_bus();
    chk_apb("e2acc.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("e2acc.paddr", PADDR, 32'h60);
    tick();
    tick();
    chk_apb("e2acc.done", 1'b0, 1'b0, 1'b1, 1'b0);
    sb_check("e2acc.hrdata");

    // Timeout: PREADY stuck low, TIMEOUT=4.
    present(1'b0, 32'h0000_0070);
    PREADY = 1'b0;
    tick();
    idle_bus();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_apb("to.acc", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_apb("to.err1", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_apb("to.err2", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_apb("to.idle", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("to.hrdata", HRDATA, 32'h600D_0060);

    // Reset pulse during ACCESS, then a normal read.
    present(1'b0, 32'h0000_0080);
    tick();
    idle_bus();
    tick();
    chk_apb("rsta.acc", 1'b1, 1'b1, 1'b0, 1'b0);
    #1 PRESETn = 1'b0;
    #1;
    chk_apb("rsta.rst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rsta.hrdata", HRDATA, 32'd0);
    #1 PRESETn = 1'b1;
    PREADY = 1'b1;
    tick();
    chk_apb("rsta.idle", 1'b0, 1'b0, 1'b1, 1'b0);
    present(1'b0, 32'h0000_0090);
    PRDATA = 32'h1357_9BDF;
    sb_q.push_back(32'h1357_9BDF);
    tick();
    idle_bus();
    chk_apb("rsta.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_apb("rsta.done", 1'b0, 1'b0, 1'b1, 1'b0);
    sb_check("rsta.hrdata");

    chk("sb.empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb2apb_bridge.md
AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS cycles before a forced error; 0 disables the timeout; legal range 0..255.
REQ-002 SHALL have ports:
- PCLK  in  1  clock for both the AHB and APB sides; single clock domain.
- PRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  AHB slave select.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type.
- HWRITE  in  1  AHB write, 1 = write.
- HWDATA  in  32  AHB write data, valid in the data phase.
- HREADYIN  in  1  AHB bus ready.
- HREADYOUT  out  1  bridge ready.
- HRDATA  out  32  AHB read data.
- HRESP  out  1  AHB response, 1 = ERROR.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.
REQ-003 All outputs SHALL be registered or decoded from state only; no combinational path from AHB inputs to APB outputs.

Function
REQ-004 SHALL implement the FSM states IDLE, WDATA, SETUP, ACCESS, ERR1 and ERR2.
REQ-005 A transfer SHALL be accepted in IDLE when HSEL=1, HREADYIN=1 and HTRANS[1]=1 (NONSEQ or SEQ); IDLE and BUSY transfers, or HSEL=0, SHALL be ignored with no APB activity.
REQ-006 On acceptance, SHALL latch HADDR into PADDR and HWRITE into PWRITE; next state SHALL be WDATA for writes and SETUP for reads.
REQ-007 WDATA SHALL last 1 cycle, capture HWDATA into PWDATA at its end, then go to SETUP.
REQ-008 SETUP SHALL drive PSEL=1, PENABLE=0 for exactly 1 cycle, then go to ACCESS.
REQ-009 ACCESS SHALL drive PSEL=1, PENABLE=1 and hold PADDR, PWRITE and PWDATA stable until PREADY=1.
REQ-010 In ACCESS with PREADY=1 and PSLVERR=0:
- read: capture PRDATA into HRDATA.
- next state IDLE; PSEL and PENABLE go to 0.
REQ-011 In ACCESS with PREADY=1 and PSLVERR=1: next state ERR1; HRDATA SHALL be unchanged.
REQ-012 Timeout: the ACCESS cycle counter SHALL reset to 0 on entering ACCESS. If TIMEOUT>0 and the counter reaches TIMEOUT-1 with PREADY=0, the FSM SHALL go to ERR1 and drop PSEL and PENABLE.
REQ-013 ERR1 SHALL drive HREADYOUT=0, HRESP=1. ERR2 SHALL drive HREADYOUT=1, HRESP=1 and behave as IDLE for acceptance (REQ-005).
REQ-014 HREADYOUT SHALL be 1 only in IDLE and ERR2. HRESP SHALL be 1 only in ERR1 and ERR2.
REQ-015 Zero-wait-state latency SHALL be fixed:
- read: accept at T0, SETUP T1, ACCESS T2, HREADYOUT=1 with data at T3.
- write: accept at T0, WDATA T1, SETUP T2, ACCESS T3, HREADYOUT=1 at T4.
REQ-016 Back-to-back: a transfer presented in the same IDLE/ERR2 cycle that completes the previous one SHALL be accepted; there SHALL be no idle APB cycle beyond REQ-015.
REQ-017 Write transfers SHALL leave HRDATA unchanged.

Reset
REQ-018 Asserting PRESETn=0 SHALL asynchronously force:
- state IDLE;
- PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
- HRDATA=0, HRESP=0, HREADYOUT=1;
- timeout counter 0.
REQ-019 Reset mid-transfer (any state) SHALL abort it with no error response. The first accept after deassertion SHALL occur no earlier than the first PCLK rising edge with PRESETn=1.

Verification
REQ-020 Write 0xDEADBEEF to 0x0000_0010, PREADY=1 -> PSEL=1 for T2-T3, PENABLE=1 at T3 only, PADDR=0x10 and PWDATA=0xDEADBEEF through T2-T3, HREADYOUT=1 at T4.
REQ-021 Read 0x0000_0010, PRDATA=0x12345678, PREADY=1 -> HRDATA=0x12345678 with HREADYOUT=1 at T3, HRESP=0.
REQ-022 Read with PREADY held 0 for 3 ACCESS cycles -> ACCESS lasts 4 cycles, signals stable throughout, HREADYOUT=0 until completion.
REQ-023 Write with PSLVERR=1 at PREADY -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then HRESP=0.
REQ-024 TIMEOUT=4 and PREADY stuck 0 -> ACCESS exactly 4 cycles, PSEL drops, two-cycle ERROR response.
REQ-025 PRESETn pulsed low during ACCESS -> PSEL, PENABLE and HRESP go to 0 immediately and HREADYOUT=1; the next read completes normally.
